// File: rtl/dff_chain_pkg.sv
// Shared definitions for the D-register shift chain: mode encoding and width.
package dff_chain_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_SHIFT  = 2'b01;
  localparam mode_t MODE_LOAD   = 2'b10;
  localparam mode_t MODE_ROTATE = 2'b11;

endpackage : dff_chain_pkg

// File: rtl/dff_sync_en.sv
// Single WIDTH-bit register with synchronous active-high reset and a load enable.
module dff_sync_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Reset wins over enable; otherwise capture d only when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : dff_sync_en

// File: rtl/dff_shift_chain.sv
// WIDTH x DEPTH register chain with hold, shift, parallel load and rotate
// modes, plus a saturating count of how many stages hold valid data.
module dff_shift_chain
  import dff_chain_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [MODE_W-1:0]            mode,
  input  logic [WIDTH-1:0]             din,
  input  logic [WIDTH*DEPTH-1:0]       load_data,
  output logic [WIDTH-1:0]             dout,
  output logic [WIDTH*DEPTH-1:0]       taps,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Next value for every stage; stage 0 is the only one whose source differs
  // between shift (serial input) and rotate (wrap from the oldest stage).
  always_comb begin
    stage_d[0] = stage_q[0];
    case (mode)
      MODE_SHIFT:  stage_d[0] = din;
      MODE_LOAD:   stage_d[0] = load_data[0 +: WIDTH];
      MODE_ROTATE: stage_d[0] = stage_q[DEPTH-1];
      default:     stage_d[0] = stage_q[0];
    endcase
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
      case (mode)
        MODE_SHIFT:  stage_d[k] = stage_q[k-1];
        MODE_LOAD:   stage_d[k] = load_data[k*WIDTH +: WIDTH];
        MODE_ROTATE: stage_d[k] = stage_q[k-1];
        default:     stage_d[k] = stage_q[k];
      endcase
    end
  end

  // One enabled register per stage; enable low freezes the whole chain.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_sync_en #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (en),
      .d_i   (stage_d[g]),
      .q_o   (stage_q[g])
    );
    assign taps[g*WIDTH +: WIDTH] = stage_q[g];
  end

  // Valid-stage bookkeeping: shift fills up to DEPTH, load fills at once.
  always_comb begin
    count_d = count_q;
    case (mode)
      MODE_SHIFT: begin
        if (count_q != DEPTH_C) begin
          count_d = count_q + CW'(1);
        end
      end
      MODE_LOAD: count_d = DEPTH_C;
      default:   count_d = count_q;
    endcase
  end

  // Count register shares reset and enable priority with the data stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_d;
    end
  end

  assign dout  = stage_q[DEPTH-1];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);

endmodule : dff_shift_chain

// File: tb/tb_dff_shift_chain.sv
// Directed bench for dff_shift_chain with a scoreboard of expected outputs.
module tb_dff_shift_chain;
  import dff_chain_pkg::*;

  localparam int              W  = 8;
  localparam int              D  = 4;
  localparam int              TW = W * D;
  localparam logic [W-1:0]    RV = 8'hA5;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [1:0]     mode;
  logic [W-1:0]   din;
  logic [TW-1:0]  loadData;
  logic [W-1:0]   dout;
  logic [TW-1:0]  taps;
  logic [2:0]     count;
  logic           full;

  typedef struct {
    string         tag;
    logic [TW-1:0] taps;
    logic [W-1:0]  dout;
    logic [2:0]    count;
    logic          full;
  } exp_t;

  exp_t          sb[$];
  logic [TW-1:0] mTaps;
  int            mCount;
  int            errors = 0;
  int            checks = 0;

  dff_shift_chain #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .load_data (loadData),
    .dout      (dout),
    .taps      (taps),
    .count     (count),
    .full      (full)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Generic comparison with a failure report.
  task automatic checkVal(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it to the registered outputs.
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries, want >0");
      return;
    end
    e = sb.pop_front();
    checkVal({e.tag, ".taps"},  taps,                e.taps);
    checkVal({e.tag, ".dout"},  TW'(dout),           TW'(e.dout));
    checkVal({e.tag, ".count"}, TW'(count),          TW'(e.count));
    checkVal({e.tag, ".full"},  TW'(full),           TW'(e.full));
  endtask

  // Drive one cycle of inputs, predict the result, wait for the edge, check.
  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic [1:0] m, input logic [W-1:0] dv,
                               input logic [TW-1:0] ld);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; din = dv; loadData = ld;
    if (r) begin
      mTaps  = {D{RV}};
      mCount = 0;
    end else if (e) begin
      case (m)
        MODE_SHIFT: begin
          mTaps = {mTaps[TW-W-1:0], dv};
          if (mCount < D) mCount++;
        end
        MODE_LOAD: begin
          mTaps  = ld;
          mCount = D;
        end
        MODE_ROTATE: mTaps = {mTaps[TW-W-1:0], mTaps[TW-1 -: W]};
        default: ;
      endcase
    end
    x.tag   = tag;
    x.taps  = mTaps;
    x.dout  = mTaps[TW-1 -: W];
    x.count = 3'(mCount);
    x.full  = (mCount == D);
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = MODE_SHIFT; din = '0; loadData = '0;
    mTaps = '0; mCount = 0;

    // Reset held two cycles while shifting is requested.
    applyStimulus("rst0", 1'b1, 1'b1, MODE_SHIFT, 8'h99, '0);
    applyStimulus("rst1", 1'b1, 1'b1, MODE_SHIFT, 8'h98, '0);
    checkVal("reset_taps", taps, 32'hA5A5A5A5);
    checkVal("reset_full", TW'(full), '0);

    // Shift fill.
    applyStimulus("fill1", 1'b0, 1'b1, MODE_SHIFT, 8'h01, '0);
    applyStimulus("fill2", 1'b0, 1'b1, MODE_SHIFT, 8'h02, '0);
    applyStimulus("fill3", 1'b0, 1'b1, MODE_SHIFT, 8'h03, '0);
    checkVal("fill3_not_full", TW'(full), '0);
    applyStimulus("fill4", 1'b0, 1'b1, MODE_SHIFT, 8'h04, '0);
    checkVal("fill_taps", taps, 32'h01020304);
    checkVal("fill_dout", TW'(dout), TW'(8'h01));
    checkVal("fill_full", TW'(full), TW'(1'b1));
    applyStimulus("fill5", 1'b0, 1'b1, MODE_SHIFT, 8'h05, '0);
    checkVal("sat_dout", TW'(dout), TW'(8'h02));
    checkVal("sat_count", TW'(count), TW'(3'd4));

    // Load then rotate around.
    applyStimulus("load", 1'b0, 1'b1, MODE_LOAD, 8'h00, 32'h44332211);
    checkVal("load_taps", taps, 32'h44332211);
    applyStimulus("rot1", 1'b0, 1'b1, MODE_ROTATE, 8'h00, '0);
    checkVal("rot1_taps", taps, 32'h33221144);
    applyStimulus("rot2", 1'b0, 1'b1, MODE_ROTATE, 8'h00, '0);
    applyStimulus("rot3", 1'b0, 1'b1, MODE_ROTATE, 8'h00, '0);
    applyStimulus("rot4", 1'b0, 1'b1, MODE_ROTATE, 8'h00, '0);
    checkVal("rot4_taps", taps, 32'h44332211);
    applyStimulus("hold", 1'b0, 1'b1, MODE_HOLD, 8'hEE, 32'hDEADBEEF);

    // Enable gating in the middle of a fill.
    applyStimulus("egRst", 1'b1, 1'b0, MODE_HOLD, 8'h00, '0);
    applyStimulus("eg1", 1'b0, 1'b1, MODE_SHIFT, 8'h11, '0);
    applyStimulus("eg2", 1'b0, 1'b1, MODE_SHIFT, 8'h22, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("egOff", 1'b0, 1'b0, MODE_SHIFT, (i[0] ? 8'hFF : 8'h5A), 32'hCAFEF00D);
    end
    checkVal("eg_hold_taps", taps, 32'hA5A51122);
    applyStimulus("eg3", 1'b0, 1'b1, MODE_SHIFT, 8'h33, '0);
    applyStimulus("eg4", 1'b0, 1'b1, MODE_SHIFT, 8'h44, '0);
    checkVal("eg_resume_taps", taps, 32'h11223344);

    // Partial fill then load reports a full chain.
    applyStimulus("pfRst", 1'b1, 1'b1, MODE_LOAD, 8'h00, 32'h12345678);
    applyStimulus("pf1", 1'b0, 1'b1, MODE_SHIFT, 8'hC1, '0);
    applyStimulus("pfLoad", 1'b0, 1'b1, MODE_LOAD, 8'h00, 32'h0F1E2D3C);
    checkVal("pf_count", TW'(count), TW'(3'd4));

    // Reset on the third edge of a shift burst.
    applyStimulus("mb1", 1'b0, 1'b1, MODE_SHIFT, 8'h61, '0);
    applyStimulus("mb2", 1'b0, 1'b1, MODE_SHIFT, 8'h62, '0);
    applyStimulus("mbRst", 1'b1, 1'b1, MODE_SHIFT, 8'h77, '0);
    checkVal("mb_taps", taps, 32'hA5A5A5A5);
    checkVal("mb_count", TW'(count), '0);
    applyStimulus("mbAfter", 1'b0, 1'b1, MODE_SHIFT, 8'h88, '0);
    checkVal("mb_after_taps", taps, 32'hA5A5A588);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dff_shift_chain

// File: doc/dff_shift_chain.md
# dff_shift_chain

Parametrised chain of synchronous-reset D registers, generalising the single D flip-flop into a WIDTH-bit by DEPTH-stage register array. It supports hold, serial shift, parallel load and rotate modes, and tracks how many stages hold valid data. It sits between sampling front-ends and downstream logic as a configurable delay line, deserialiser or circular buffer.

## Interface
- WIDTH, 8: bits per stage, at least 1
- DEPTH, 4: number of stages, at least 2
- RESET_VAL, 0: value every stage takes on reset, WIDTH bits
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; 0 means all state holds regardless of mode
- mode  input  2  operating mode: 00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
- din  input  WIDTH  serial input word for SHIFT
- load_data  input  WIDTH*DEPTH  parallel load word; stage k is at [k*WIDTH +: WIDTH]
- dout  output  WIDTH  stage DEPTH-1, the oldest word
- taps  output  WIDTH*DEPTH  all stages, packed as for load_data
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- full  output  1  high when count == DEPTH

## Operation
- State is stage[0..DEPTH-1], each WIDTH bits, plus count.
- Priority at each rising edge: rst, then en, then mode.
- rst=1: every stage takes RESET_VAL and count goes to 0, whatever en and mode are.
- en=0: no state changes.
- HOLD: no state changes.
- SHIFT: stage[0] takes din and stage[k] takes stage[k-1] for k ≥ 1. The old stage[DEPTH-1] is discarded. count increments and saturates at DEPTH.
- LOAD: stage[k] takes load_data[k*WIDTH +: WIDTH]. count is set to DEPTH.
- ROTATE: stage[0] takes stage[DEPTH-1] and stage[k] takes stage[k-1]. count is unchanged, and no data is lost.
- Outputs are driven directly from registers:
  - dout = stage[DEPTH-1]
  - taps = packed stages
  - full = (count == DEPTH)
- count is bookkeeping only and never gates data movement. SHIFT while full still shifts.

## Timing
- Reset values: dout = RESET_VAL, taps = RESET_VAL replicated, count = 0, full = 0. These are visible the cycle after the rst edge.
- A word accepted by SHIFT at edge n appears on dout after edge n+DEPTH-1, assuming DEPTH consecutive SHIFT cycles with en=1.
- LOAD: taps equals load_data after a single edge.
- ROTATE: DEPTH consecutive rotates return taps to its original value.
- full rises on the edge where count reaches DEPTH. That is the DEPTH-th SHIFT since reset, or any LOAD.
- Boundary cases:
  - Inputs change only at the clock. There are no combinational paths from any input to any output.
  - rst asserted mid-operation, e.g. during a SHIFT burst, clears everything on that same edge. The operation does not complete.
  - en low for N cycles stretches latency by N cycles. Data is preserved.
  - Mode changes take effect on the next edge. A pipeline that is partially filled and then LOADed reports count = DEPTH.

## Structure
- Shared package dff_chain_pkg holds:
  - mode localparams MODE_HOLD, MODE_SHIFT, MODE_LOAD, MODE_ROTATE
  - the 2-bit mode width constant
- Sub-module dff_sync_en: one WIDTH-bit register with synchronous active-high reset to RESET_VAL, an enable, and a D input.
  - Instantiate it DEPTH times in a generate loop.
  - The parent computes each stage's next-value mux from mode.
- The count register and saturation logic live in the parent.

## Test plan
- Reset: hold rst=1 for 2 cycles with en=1 and mode=SHIFT, WIDTH=8, DEPTH=4, RESET_VAL=8'hA5. Required: taps=32'hA5A5A5A5, count=0, full=0.
- Shift fill: SHIFT din=01,02,03,04 on consecutive edges. Required:
  - dout=01 after the 4th edge
  - taps=32'h01020304 (stage3..stage0)
  - count=4, full rises on the 4th edge
  - a 5th SHIFT with din=05 gives dout=02 and count stays 4
- Load and rotate: LOAD load_data=32'h44332211, then ROTATE ×1. Required:
  - after the load, taps=32'h44332211 and full=1
  - after the rotate, taps=32'h33221144 and count stays 4
  - 3 more rotates restore 32'h44332211
- Enable gating: mid-fill, after 2 shifts, drop en for 3 cycles while mode=SHIFT and din toggles. Required: taps and count unchanged; the fill resumes correctly when en returns.
- Reset mid-burst: assert rst on the 3rd edge of a SHIFT burst. Required: all stages are RESET_VAL and count=0 on that edge; din on that edge is not captured.
